// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// State encodings and the latched request bundle live here.
package arb_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = IDLE,
        S_ACCESS = ACCESS,
        S_RESP   = RESP
    } state_t;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;
    localparam int REQ_W  = ADDR_W + DATA_W + BE_W + 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
        logic [BE_W-1:0]   byte_en;
        logic              rd_en;
        logic              wr_en;
    } bus_req_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Core-style memory bus port: the master drives a request, the slave answers
// with read data, busy and a timeout error pulse.
interface mem_bus_arbiter_if;
    import arb_pkg::*;

    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   byte_en;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              err;

    modport master (
        output rd_en, wr_en, addr, wr_data, byte_en,
        input  rd_data, busy, err
    );

    modport slave (
        input  rd_en, wr_en, addr, wr_data, byte_en,
        output rd_data, busy, err
    );
endinterface

// File: rtl/mem_bus_arbiter_busy_timeout_counter.sv
// Counts consecutive busy cycles of one access; expired flags the cycle whose
// busy sample would bring the count up to TIMEOUT.
module busy_timeout_counter #(
    parameter int TIMEOUT = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory bus between two core-style
// masters; the grant is held for a whole transaction and stuck accesses abort.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT      = 256,
    parameter int ZERO_WAIT_OK = 1
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_busy,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [BE_W-1:0]   mem_byte_en,
    output logic              grant
);
    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              rr_last_q, rr_last_d;
    logic              err_q, err_d;
    logic              first_q, first_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    bus_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic     m0_req, m1_req;
    bus_req_t m0_bus, m1_bus;
    logic     cnt_clear, cnt_en, expired, done;

    assign m0_req = m0.rd_en | m0.wr_en;
    assign m1_req = m1.rd_en | m1.wr_en;
    assign m0_bus = {m0.addr, m0.wr_data, m0.byte_en, m0.rd_en, m0.wr_en};
    assign m1_bus = {m1.addr, m1.wr_data, m1.byte_en, m1.rd_en, m1.wr_en};

    // Holding the counter clear throughout IDLE guarantees it starts at zero on ACCESS entry.
    assign cnt_clear = (state_q == S_IDLE);
    assign cnt_en    = (state_q == S_ACCESS) && mem_busy;
    assign done      = (state_q == S_ACCESS) && !mem_busy && ((ZERO_WAIT_OK != 0) || !first_q);

    busy_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        err_d     = err_q;
        first_d   = first_q;
        rd_en_d   = rd_en_q;
        wr_en_d   = wr_en_q;
        req_d     = req_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d = (m0_req && m1_req) ? ~rr_last_q : m1_req;
                    req_d   = grant_d ? m1_bus : m0_bus;
                    // A request with both enables set is treated as a write.
                    rd_en_d = req_d.rd_en & ~req_d.wr_en;
                    wr_en_d = req_d.wr_en;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                first_d = 1'b0;
                if (done) begin
                    if (rd_en_q) begin
                        if (grant_q) rdata1_d = mem_rd_data;
                        else         rdata0_d = mem_rd_data;
                    end
                    rr_last_d = grant_q;
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    state_d   = S_RESP;
                end else if (expired) begin
                    err_d   = 1'b1;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            err_q     <= 1'b0;
            first_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            req_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
            first_q   <= first_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            req_q     <= req_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign mem_addr    = req_q.addr;
    assign mem_wr_data = req_q.wr_data;
    assign mem_byte_en = req_q.byte_en;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign grant       = grant_q;

    // The granted master stays busy through ACCESS even if it drops its enables.
    assign m0.busy    = (m0_req && ((state_q != S_RESP) || grant_q))
                      || ((state_q == S_ACCESS) && !grant_q);
    assign m1.busy    = (m1_req && ((state_q != S_RESP) || !grant_q))
                      || ((state_q == S_ACCESS) && grant_q);
    assign m0.err     = (state_q == S_RESP) && !grant_q && err_q;
    assign m1.err     = (state_q == S_RESP) && grant_q && err_q;
    assign m0.rd_data = rdata0_q;
    assign m1.rd_data = rdata1_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, round-robin contention, zero-wait
// reads, wait-state writes, timeout abort and reset during an access.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] mem_rd_data;
    logic        mem_busy;
    logic [63:0] mem_wr_data;
    logic [63:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [7:0]  mem_byte_en;
    logic        grant;

    int n_checks = 0;
    int n_err    = 0;

    mem_bus_arbiter_if m0_if ();
    mem_bus_arbiter_if m1_if ();

    mem_bus_arbiter #(
        .TIMEOUT      (8),
        .ZERO_WAIT_OK (1)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .mem_rd_data (mem_rd_data),
        .mem_busy    (mem_busy),
        .mem_wr_data (mem_wr_data),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_byte_en (mem_byte_en),
        .grant       (grant)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_rd_data = '0;
        mem_busy = 1'b0;
        m0_if.rd_en = 0; m0_if.wr_en = 0; m0_if.addr = '0; m0_if.wr_data = '0; m0_if.byte_en = '0;
        m1_if.rd_en = 0; m1_if.wr_en = 0; m1_if.addr = '0; m1_if.wr_data = '0; m1_if.byte_en = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wr_data, 0);
        chk("rst_be", mem_byte_en, 0);
        chk("rst_grant", grant, 0);
        chk("rst_m0_rdata", m0_if.rd_data, 0);
        chk("rst_m1_rdata", m1_if.rd_data, 0);
        chk("rst_m0_err", m0_if.err, 0);
        chk("rst_m0_busy", m0_if.busy, 0);

        // Contention from reset: grants alternate 0,1,0,1, three cycles each.
        m0_if.rd_en = 1; m0_if.addr = 64'h1000; m0_if.byte_en = 8'hFF;
        m1_if.rd_en = 1; m1_if.addr = 64'h2000; m1_if.byte_en = 8'hFF;
        for (int a = 0; a < 4; a++) begin
            logic g;
            g = a[0];
            step();
            mem_rd_data = 64'h100 + 64'(a);
            #1;
            chk($sformatf("rr%0d_grant", a), grant, g);
            chk($sformatf("rr%0d_rd_en", a), mem_rd_en, 1);
            chk($sformatf("rr%0d_addr", a), mem_addr, g ? 64'h2000 : 64'h1000);
            chk($sformatf("rr%0d_m0_busy_acc", a), m0_if.busy, 1);
            chk($sformatf("rr%0d_m1_busy_acc", a), m1_if.busy, 1);
            step();
            chk($sformatf("rr%0d_m0_busy_resp", a), m0_if.busy, g ? 1'b1 : 1'b0);
            chk($sformatf("rr%0d_m1_busy_resp", a), m1_if.busy, g ? 1'b0 : 1'b1);
            chk($sformatf("rr%0d_rdata", a), g ? m1_if.rd_data : m0_if.rd_data, 64'h100 + 64'(a));
            chk($sformatf("rr%0d_rd_en_resp", a), mem_rd_en, 0);
            step();
            chk($sformatf("rr%0d_rd_en_idle", a), mem_rd_en, 0);
            if (a == 3) begin
                m0_if.rd_en = 0;
                m1_if.rd_en = 0;
            end
        end
        chk("rr_m0_rdata_final", m0_if.rd_data, 64'h102);
        chk("rr_m1_rdata_final", m1_if.rd_data, 64'h103);

        // Single zero-wait read on m0.
        m0_if.rd_en = 1; m0_if.addr = 64'h1000;
        mem_rd_data = 64'hDEADBEEF;
        #1;
        chk("t1_busy_idle", m0_if.busy, 1);
        chk("t1_rd_en_idle", mem_rd_en, 0);
        step();
        chk("t1_rd_en_acc", mem_rd_en, 1);
        chk("t1_addr", mem_addr, 64'h1000);
        chk("t1_grant", grant, 0);
        chk("t1_busy_acc", m0_if.busy, 1);
        step();
        chk("t1_rd_en_resp", mem_rd_en, 0);
        chk("t1_busy_resp", m0_if.busy, 0);
        chk("t1_rdata", m0_if.rd_data, 64'hDEADBEEF);
        chk("t1_err", m0_if.err, 0);
        m0_if.rd_en = 0;
        step();
        chk("t1_rd_en_idle2", mem_rd_en, 0);
        chk("t1_busy_idle2", m0_if.busy, 0);

        // Both enables high on m0: issued as a write, read data untouched.
        m0_if.rd_en = 1; m0_if.wr_en = 1; m0_if.addr = 64'h40; m0_if.wr_data = 64'h1234;
        mem_rd_data = 64'hBAD;
        step();
        chk("t6_wr_en", mem_wr_en, 1);
        chk("t6_rd_en", mem_rd_en, 0);
        chk("t6_wdata", mem_wr_data, 64'h1234);
        step();
        chk("t6_rdata", m0_if.rd_data, 64'hDEADBEEF);
        chk("t6_busy_resp", m0_if.busy, 0);
        m0_if.rd_en = 0; m0_if.wr_en = 0;
        step();

        // m1 write with four wait states.
        m1_if.wr_en = 1; m1_if.addr = 64'h30; m1_if.wr_data = 64'h55AA; m1_if.byte_en = 8'h0F;
        mem_busy = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) begin
            mem_busy = (k < 5);
            #1;
            chk($sformatf("t3_c%0d_wr_en", k), mem_wr_en, 1);
            chk($sformatf("t3_c%0d_addr", k), mem_addr, 64'h30);
            chk($sformatf("t3_c%0d_wdata", k), mem_wr_data, 64'h55AA);
            chk($sformatf("t3_c%0d_be", k), mem_byte_en, 8'h0F);
            chk($sformatf("t3_c%0d_grant", k), grant, 1);
            chk($sformatf("t3_c%0d_busy", k), m1_if.busy, 1);
            step();
        end
        chk("t3_wr_en_resp", mem_wr_en, 0);
        chk("t3_busy_resp", m1_if.busy, 0);
        chk("t3_rdata", m1_if.rd_data, 64'h103);
        chk("t3_err", m1_if.err, 0);
        m1_if.wr_en = 0;
        step();

        // Timeout: memory stuck busy, abort after 8 ACCESS cycles.
        m0_if.rd_en = 1; m0_if.addr = 64'h80;
        mem_busy = 1'b1;
        mem_rd_data = 64'h5555;
        step();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("t4_c%0d_rd_en", k), mem_rd_en, 1);
            chk($sformatf("t4_c%0d_err", k), m0_if.err, 0);
            chk($sformatf("t4_c%0d_busy", k), m0_if.busy, 1);
            step();
        end
        chk("t4_err_resp", m0_if.err, 1);
        chk("t4_busy_resp", m0_if.busy, 0);
        chk("t4_rd_en_resp", mem_rd_en, 0);
        chk("t4_wr_en_resp", mem_wr_en, 0);
        chk("t4_rdata", m0_if.rd_data, 64'hDEADBEEF);
        m0_if.rd_en = 0;
        mem_busy = 1'b0;
        step();
        chk("t4_err_idle", m0_if.err, 0);
        chk("t4_rd_en_idle", mem_rd_en, 0);

        // A completed m0 read afterwards leaves rr_last pointing at master 0.
        m0_if.rd_en = 1; m0_if.addr = 64'h1000;
        mem_rd_data = 64'h77;
        step();
        chk("t4b_rd_en", mem_rd_en, 1);
        step();
        chk("t4b_rdata", m0_if.rd_data, 64'h77);
        m0_if.rd_en = 0;
        step();

        // Reset in the middle of a busy m1 write.
        m1_if.wr_en = 1; m1_if.addr = 64'h50; m1_if.wr_data = 64'h99; m1_if.byte_en = 8'hFF;
        mem_busy = 1'b1;
        step();
        chk("t5_wr_en_acc", mem_wr_en, 1);
        chk("t5_grant_acc", grant, 1);
        step();
        rst = 1'b1;
        m1_if.wr_en = 0;
        step();
        chk("t5_wr_en_rst", mem_wr_en, 0);
        chk("t5_err_rst", m1_if.err, 0);
        chk("t5_grant_rst", grant, 0);
        chk("t5_m0_rdata_rst", m0_if.rd_data, 0);
        rst = 1'b0;
        mem_busy = 1'b0;
        m0_if.rd_en = 1; m0_if.addr = 64'h1000;
        m1_if.rd_en = 1; m1_if.addr = 64'h2000;
        step();
        chk("t5_tie_grant", grant, 0);
        chk("t5_tie_addr", mem_addr, 64'h1000);
        chk("t5_err_acc", m1_if.err, 0);
        step();
        m0_if.rd_en = 0;
        m1_if.rd_en = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 64-bit memory bus (rd_data/wr_data/mem_addr/mem_busy/rd_en/wr_en/byte_en) between two masters.
- Master 0 is the RV64I core; master 1 is a second bus master (DMA/debug loader).
- Each master sees a port identical to the core's bus interface, so the core connects unchanged.
- Performs round-robin arbitration, holds the grant for one whole transaction, and aborts accesses that exceed a busy timeout.

Parameters:
- TIMEOUT, 256: max consecutive ACCESS cycles with mem_busy=1 before abort (≥2).
- ZERO_WAIT_OK, 1: 1 = completion allowed in the first ACCESS cycle; 0 = at least 2 ACCESS cycles.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- m0_rd_en, m0_wr_en  in  1 each  master 0 request
- m0_addr  in  64  master 0 address
- m0_wr_data  in  64  master 0 write data
- m0_byte_en  in  8  master 0 byte enables
- m0_rd_data  out  64  master 0 read data
- m0_busy  out  1  master 0 request not yet complete
- m0_err  out  1  one-cycle pulse: master 0 access timed out
- m1_*  same set as m0_*, for master 1
- mem_rd_data  in  64  memory read data
- mem_busy  in  1  memory access in progress
- mem_wr_data  out  64  memory write data
- mem_addr  out  64  memory address
- mem_rd_en, mem_wr_en  out  1 each  memory enables
- mem_byte_en  out  8  memory byte enables
- grant  out  1  index of the master currently owning the bus (debug)

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high. Nothing changes asynchronously.
- Requests: masterX requests when mX_rd_en|mX_wr_en is high. If both are set, the access is a write.
- States: IDLE, ACCESS, RESP.
- IDLE: mem enables 0.
  - Sample requests; if any is present, register the grant, latch addr/wr_data/byte_en/rd-or-wr from the granted master, and go to ACCESS.
  - Both request: grant the master that did not win last (rr_last). After reset rr_last=1, so master 0 wins the first tie.
- ACCESS: drive mem_* from the latched fields with the selected enable high.
  - Memory asserts mem_busy combinationally in cycles where it is not done.
  - Completion: first ACCESS cycle with mem_busy=0, subject to ZERO_WAIT_OK=0 requiring ≥2 cycles. On that edge, latch mem_rd_data into that master's rd_data register, update rr_last, go to RESP.
  - Timeout: a 9-bit (clog2) counter clears on entry to ACCESS and increments each busy cycle. On reaching TIMEOUT: go to RESP with the error flag set; rd_data is not updated.
- RESP: one cycle; mem enables 0.
  - Granted master's busy=0; mX_err=1 if timed out.
  - Next state is always IDLE.
  - The requester must drop its enables in the cycle after it sees busy=0; an enable still high in IDLE is a new request.
- mX_busy (combinational):
  - 1 when mX has an enable high and (state != RESP or grant != X).
  - Also 1 for the granted master throughout ACCESS, even if the enable is dropped (no cancel supported).
- mX_rd_data: holds its last latched value until the next completed read for X. The other master's register is never touched.
- Latency with a zero-wait memory: request in IDLE at T → ACCESS T+1 → RESP T+2 (busy low) → IDLE T+3. Minimum 3 cycles per access; back-to-back accesses alternate masters.
- Inputs of the non-granted master are ignored until IDLE.
- Reset values: state=IDLE, grant=0, rr_last=1, counter=0, all rd_data registers=0, all mem enables/byte_en=0, mem_addr/wr_data=0, mX_busy follows its equation (state=IDLE), mX_err=0.
- Reset mid-ACCESS: enables are 0 from the cycle after reset is sampled; the in-flight access is dropped with no err pulse.

Decomposition:
- Shared package arb_pkg:
  - state encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - a bus-request bundle width constant (64+64+8+2).
- One sub-module: busy_timeout_counter (clear, enable, TIMEOUT parameter, expired output).

Test Plan:
1. Single read, zero-wait: m0 rd addr 0x1000, mem_rd_data 0xDEADBEEF, mem_busy=0 → mem_rd_en in T+1 only, m0_busy low at T+2, m0_rd_data=0xDEADBEEF.
2. Contention and round-robin: m0 and m1 request continuously from reset. Grants must run 0,1,0,1; each access takes 3 cycles; m1_addr=0x2000 appears on mem_addr only when grant=1.
3. Wait states: m1 write 0x55AA to 0x30 with byte_en 0x0F, mem_busy high 4 ACCESS cycles → mem_wr_en held 5 cycles with stable addr/data/byte_en, m1_busy falls in RESP, m1_rd_data unchanged.
4. Timeout: TIMEOUT=8, mem_busy stuck 1 → abort after 8 ACCESS cycles, m0_err one-cycle pulse, m0_busy low that cycle, enables 0, state back to IDLE.
5. Reset mid-ACCESS: assert reset during a busy write → mem_wr_en=0 next cycle, no err pulse, next tie grants master 0.
6. rd_en and wr_en both high on m0 → write issued (mem_wr_en=1, mem_rd_en=0), m0_rd_data unchanged.
